// File: rtl/fir_frame_ctrl_if.sv
// Sample, FIR and result buses of the FIR frame sequencer.
// master = the sequencer, slave = its environment (source, FIR, sink).
interface fir_frame_ctrl_if #(
  parameter int DW = 12,
  parameter int OW = 29
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          fir_en;
  logic [DW-1:0] fir_xin;
  logic          fir_valid;
  logic [OW-1:0] fir_yout;
  logic          m_valid;
  logic [OW-1:0] m_data;
  logic          m_last;

  modport master (
    input  s_valid, s_data, fir_valid, fir_yout,
    output s_ready, fir_en, fir_xin, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, fir_valid, fir_yout,
    input  s_ready, fir_en, fir_xin, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fir_frame_ctrl.sv
// FIR frame sequencer: accepts one frame of samples, paces them into the
// FIR at a programmable rate, optionally flushes the delay line with zeros
// and forwards the FIR results with a frame-end marker.
// Optional feature macro: FIR_FLUSH_EN (zero-sample flush of TAPS-1 samples).
module fir_frame_ctrl #(
  parameter int DW     = 12,
  parameter int OW     = 29,
  parameter int LEN_W  = 16,
  parameter int TAPS   = 16,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [RATE_W-1:0] rate_div,
  output logic              busy,
  output logic              done,
  fir_frame_ctrl_if.master  bus
);

`ifdef FIR_FLUSH_EN
  localparam int FLUSH_N = TAPS - 1;
`else
  localparam int FLUSH_N = 0;
`endif
  localparam int CW = LEN_W + 1;
  localparam int FW = $clog2(TAPS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [RATE_W-1:0] div_q, div_d;
  logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
  logic [CW-1:0]     in_cnt_q, in_cnt_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
  logic              done_q, done_d;
  logic              fir_en_q, fir_en_d;
  logic [DW-1:0]     fir_xin_q, fir_xin_d;
  logic              m_valid_q, m_valid_d;
  logic [OW-1:0]     m_data_q, m_data_d;
  logic              m_last_q, m_last_d;

  logic          tick;
  logic          take;
  logic          issue_flush;
  logic          out_beat;
  logic [CW-1:0] last_idx;

  // A sample may issue only when the pacing counter has run out.
  assign tick        = (rate_cnt_q == '0);
  assign bus.s_ready = (state_q == ST_RUN) && tick;
  assign take        = bus.s_valid && bus.s_ready;
  assign issue_flush = (state_q == ST_FLUSH) && tick;
  assign out_beat    = bus.fir_valid && (state_q != ST_IDLE);
  // Index of the final result: len + flush length - 1 (never wraps, CW bits).
  assign last_idx    = CW'(len_q) + CW'(FLUSH_N) - CW'(1);

  // Next-state, pacing, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    div_d       = div_q;
    rate_cnt_d  = rate_cnt_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    fir_en_d    = 1'b0;
    fir_xin_d   = fir_xin_q;
    m_valid_d   = 1'b0;
    m_data_d    = m_data_q;
    m_last_d    = 1'b0;

    // Reload on every issued sample, otherwise count down and hold at 0.
    if (take || issue_flush) begin
      rate_cnt_d = div_q - RATE_W'(1);
    end else if (!tick) begin
      rate_cnt_d = rate_cnt_q - RATE_W'(1);
    end

    // Results are forwarded one cycle after the FIR presents them.
    if (out_beat) begin
      m_valid_d = 1'b1;
      m_data_d  = bus.fir_yout;
      m_last_d  = (out_cnt_q == last_idx);
      out_cnt_d = out_cnt_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (frame_len != '0) begin
            state_d     = ST_RUN;
            len_d       = frame_len;
            div_d       = (rate_div == '0) ? RATE_W'(1) : rate_div;
            rate_cnt_d  = '0;
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            flush_cnt_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (take) begin
          fir_en_d  = 1'b1;
          fir_xin_d = bus.s_data;
          in_cnt_d  = in_cnt_q + CW'(1);
          if (in_cnt_q + CW'(1) == CW'(len_q)) begin
            state_d = (FLUSH_N == 0) ? ST_DRAIN : ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (issue_flush) begin
          fir_en_d    = 1'b1;
          fir_xin_d   = '0;
          flush_cnt_d = flush_cnt_q + FW'(1);
          if (int'(flush_cnt_q) == FLUSH_N - 1) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (m_valid_q && m_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort drops the frame immediately, including any result in flight.
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      fir_en_d  = 1'b0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      done_d    = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      div_q       <= '0;
      rate_cnt_q  <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
      fir_en_q    <= 1'b0;
      fir_xin_q   <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      div_q       <= div_d;
      rate_cnt_q  <= rate_cnt_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
      fir_en_q    <= fir_en_d;
      fir_xin_q   <= fir_xin_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign bus.fir_en  = fir_en_q;
  assign bus.fir_xin = fir_xin_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;

endmodule
